// File: rtl/pe_skew_buffer.sv
// rtl/pe_skew_buffer.sv - pausable diagonal skew buffer for the systolic array edge
//
// Purpose:
//   Stages a LANES-wide input vector so that lane i leaves the buffer
//   i+1+EXTRA_DEPTH advance edges after it was accepted, which produces the
//   diagonal wavefront the array expects. Every stage carries a valid bit.
//   Empty slots are zero-filled so downstream PEs accumulate 0. A small
//   IDLE/RUN/DRAIN FSM tells the controller when the wavefront has fully
//   left the buffer.
//
// Optional feature macro: PE_SKEW_BYPASS_EN
//   When defined, the skew_bypass input is added. It is sampled on the
//   IDLE->RUN edge. While the latched value is 1, every lane is taken from
//   stage 1, so all lanes have depth 1 and the FSM treats D_max as 1.
//
// Ports:
//   clk         clock
//   reset       synchronous active-high reset (highest priority)
//   pause       freeze all state
//   flush       synchronous clear of all contents, no drain pulse
//   in_valid    d carries a valid lane vector
//   in_ready    !pause && !flush (combinational)
//   d           lane vector; lane i is at [i*REG_WIDTH +: REG_WIDTH]
//   skew_bypass (PE_SKEW_BYPASS_EN only) run this burst without skew
//   q           skewed lane outputs, same packing as d
//   q_valid     per-lane valid for q
//   busy        FSM is not IDLE (registered)
//   drain_done  one-cycle pulse when the last valid word has left all lanes
module pe_skew_buffer #(
  parameter int REG_WIDTH   = 16,
  parameter int LANES       = 4,
  parameter int EXTRA_DEPTH = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pause,
  input  logic                       flush,
  input  logic                       in_valid,
`ifdef PE_SKEW_BYPASS_EN
  input  logic                       skew_bypass,
`endif
  output logic                       in_ready,
  input  logic [LANES*REG_WIDTH-1:0] d,
  output logic [LANES*REG_WIDTH-1:0] q,
  output logic [LANES-1:0]           q_valid,
  output logic                       busy,
  output logic                       drain_done
);

  localparam int DMAX = LANES + EXTRA_DEPTH;
  localparam int CW   = ($clog2(DMAX + 1) > 5) ? $clog2(DMAX + 1) : 5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   drain_cnt_q;
  logic            busy_q;
  logic            drain_done_q;
  logic            byp_q;
  logic            byp_in;
  logic [CW-1:0]   dmax_m1;

`ifdef PE_SKEW_BYPASS_EN
  assign byp_in = skew_bypass;
`else
  assign byp_in = 1'b0;
`endif

  assign in_ready   = !pause && !flush;
  assign busy       = busy_q;
  assign drain_done = drain_done_q;

  // In bypass mode the whole buffer behaves as depth 1.
  assign dmax_m1 = byp_q ? '0 : CW'(DMAX - 1);

  // Per-lane shift registers; lane l holds exactly l+1+EXTRA_DEPTH stages.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam int DL = l + 1 + EXTRA_DEPTH;

    logic [REG_WIDTH-1:0] dat_q [DL];
    logic [DL-1:0]        vld_q;

    always_ff @(posedge clk) begin
      if (reset || flush) begin
        vld_q <= '0;
        for (int s = 0; s < DL; s++) dat_q[s] <= '0;
      end else if (!pause) begin
        vld_q[0] <= in_valid;
        dat_q[0] <= in_valid ? d[l*REG_WIDTH +: REG_WIDTH] : '0;
        for (int s = 1; s < DL; s++) begin
          // Bypass bursts never reach the deeper stages, which keeps them
          // empty so IDLE still implies that no stage holds a valid word.
          if (byp_q) begin
            vld_q[s] <= 1'b0;
            dat_q[s] <= '0;
          end else begin
            vld_q[s] <= vld_q[s-1];
            dat_q[s] <= dat_q[s-1];
          end
        end
      end
    end

    assign q[l*REG_WIDTH +: REG_WIDTH] = byp_q ? dat_q[0] : dat_q[DL-1];
    assign q_valid[l]                  = byp_q ? vld_q[0] : vld_q[DL-1];
  end

  // Run/drain tracker. drain_cnt counts the remaining advance edges until
  // the last accepted word has left lane LANES-1.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_q      <= S_IDLE;
      drain_cnt_q  <= '0;
      busy_q       <= 1'b0;
      drain_done_q <= 1'b0;
      byp_q        <= 1'b0;
    end else begin
      // The pulse always lasts one cycle, even if pause follows.
      drain_done_q <= 1'b0;
      if (!pause) begin
        case (state_q)
          S_IDLE: begin
            if (in_valid) begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
              byp_q   <= byp_in;
            end
          end
          S_RUN: begin
            if (!in_valid) begin
              if (dmax_m1 == '0) begin
                state_q      <= S_IDLE;
                busy_q       <= 1'b0;
                drain_done_q <= 1'b1;
                byp_q        <= 1'b0;
              end else begin
                state_q     <= S_DRAIN;
                drain_cnt_q <= dmax_m1;
              end
            end
          end
          S_DRAIN: begin
            if (in_valid) begin
              state_q     <= S_RUN;
              drain_cnt_q <= '0;
            end else if (drain_cnt_q == CW'(1)) begin
              state_q      <= S_IDLE;
              busy_q       <= 1'b0;
              drain_done_q <= 1'b1;
              drain_cnt_q  <= '0;
              byp_q        <= 1'b0;
            end else begin
              drain_cnt_q <= drain_cnt_q - CW'(1);
            end
          end
          default: begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            drain_cnt_q <= '0;
            byp_q       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
